// File: rtl/uart_send_pkg.sv
// uart_send_pkg
// Shared types and constants for the uart_send block: transmitter state
// encoding, frame data width and send-buffer RAM geometry.
package uart_send_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int DATA_BITS = 8;

   localparam int RAM_DEPTH = 256;
   localparam int RAM_W     = 8;
   localparam int RAM_AW    = $clog2(RAM_DEPTH);

endpackage

// File: rtl/uart_send_if.sv
// uart_send_if
// Bundles the user-side signals of uart_send.
//   Transmit request : tx_data_ready, tx_data       (user -> block)
//   Transmit status  : tx, tx_busy                   (block -> user / pin)
//   Send buffer RAM  : address, data_in, write_enable (user -> block)
//                      data_out                       (block -> user)
// The master modport is the user side; the slave modport is uart_send.
interface uart_send_if;
   import uart_send_pkg::*;

   logic                 tx_data_ready;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx;
   logic                 tx_busy;
   logic [RAM_AW-1:0]    address;
   logic [RAM_W-1:0]     data_in;
   logic                 write_enable;
   logic [RAM_W-1:0]     data_out;

   modport master (
      output tx_data_ready, tx_data, address, data_in, write_enable,
      input  tx, tx_busy, data_out
   );

   modport slave (
      input  tx_data_ready, tx_data, address, data_in, write_enable,
      output tx, tx_busy, data_out
   );

endinterface

// File: rtl/uart_send_ram_block.sv
// ram_block
// 256x8 single-port send buffer with a registered, read-first output.
//   clk          : clock, rising edge
//   reset        : synchronous active-high; clears data_out and blocks writes,
//                  leaves the array contents untouched
//   address      : word address (full 8-bit range)
//   data_in      : write data
//   write_enable : write strobe
//   data_out     : registered read data (old contents during a write)
module ram_block
   import uart_send_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [RAM_AW-1:0] address,
   input  logic [RAM_W-1:0]  data_in,
   input  logic              write_enable,
   output logic [RAM_W-1:0]  data_out
);

   // Array carries no reset so it maps onto block RAM; the declaration
   // initialiser becomes the power-up (configuration) contents.
   logic [RAM_W-1:0] mem [RAM_DEPTH] = '{default: '0};

   always_ff @(posedge clk) begin
      if (write_enable && !reset) begin
         mem[address] <= data_in;
      end
   end

   // Read path samples the array before this edge's write lands (read-first).
   always_ff @(posedge clk) begin
      if (reset) begin
         data_out <= '0;
      end else begin
         data_out <= mem[address];
      end
   end

endmodule

// File: rtl/uart_send.sv
// uart_send
// 8N1 UART transmitter plus an independent 256x8 send-buffer RAM.
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high; aborts any frame in progress
//   bus    : uart_send_if.slave
//            tx_data_ready/tx_data : level request and byte to send
//            tx/tx_busy            : registered serial line and busy flag
//            address/data_in/write_enable/data_out : send-buffer RAM port
// Parameters: CLK_FREQ, BAUD, CLKS_PER_BIT (>= 2, cycles per bit).
module uart_send
   import uart_send_pkg::*;
#(
   parameter int CLK_FREQ     = 12_000_000,
   parameter int BAUD         = 115200,
   parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
)(
   input  logic       clk,
   input  logic       reset,
   uart_send_if.slave bus
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   tx_state_t            state, state_n;
   logic [BAUD_W-1:0]    baud_cnt, baud_cnt_n;
   logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic                 tx_q, tx_n;
   logic                 busy_q, busy_n;
   logic                 baud_wrap;

   assign baud_wrap = (baud_cnt == BAUD_LAST);

   // State and line registers; tx/tx_busy come straight from flops so the
   // pin never glitches.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_cnt_n;
         bit_cnt  <= bit_cnt_n;
         tx_q     <= tx_n;
         busy_q   <= busy_n;
      end
   end

   // Shift register is pure data; its contents only matter once a frame
   // has been accepted, which reloads it.
   always_ff @(posedge clk) begin
      shreg <= shreg_n;
   end

   // Next-state logic. tx_n is the line level for the state being entered,
   // so each bit appears on the pin at the same edge the state changes.
   always_comb begin
      state_n    = state;
      baud_cnt_n = baud_cnt;
      bit_cnt_n  = bit_cnt;
      shreg_n    = shreg;
      tx_n       = tx_q;
      busy_n     = busy_q;

      unique case (state)
         IDLE: begin
            tx_n   = 1'b1;
            busy_n = 1'b0;
            if (bus.tx_data_ready) begin
               shreg_n    = bus.tx_data;
               baud_cnt_n = '0;
               bit_cnt_n  = '0;
               state_n    = START;
               tx_n       = 1'b0;
               busy_n     = 1'b1;
            end
         end

         START: begin
            if (baud_wrap) begin
               baud_cnt_n = '0;
               state_n    = DATA;
               tx_n       = shreg[0];
            end else begin
               baud_cnt_n = baud_cnt + BAUD_W'(1);
            end
         end

         DATA: begin
            if (baud_wrap) begin
               baud_cnt_n = '0;
               if (bit_cnt == BIT_LAST) begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end else begin
                  bit_cnt_n = bit_cnt + BIT_W'(1);
                  shreg_n   = shreg >> 1;
                  tx_n      = shreg[1];
               end
            end else begin
               baud_cnt_n = baud_cnt + BAUD_W'(1);
            end
         end

         STOP: begin
            if (baud_wrap) begin
               baud_cnt_n = '0;
               state_n    = IDLE;
               tx_n       = 1'b1;
               busy_n     = 1'b0;
            end else begin
               baud_cnt_n = baud_cnt + BAUD_W'(1);
            end
         end

         default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
         end
      endcase
   end

   assign bus.tx      = tx_q;
   assign bus.tx_busy = busy_q;

   ram_block u_ram (
      .clk          (clk),
      .reset        (reset),
      .address      (bus.address),
      .data_in      (bus.data_in),
      .write_enable (bus.write_enable),
      .data_out     (bus.data_out)
   );

endmodule

// File: tb/tb_uart_send.sv
// tb_uart_send
// Directed bench for uart_send with CLKS_PER_BIT = 4: reset values, single
// frame, back-to-back frames with a mid-frame data change, reset mid-frame,
// and the send-buffer RAM.
module tb_uart_send;

   localparam int N = 4;

   logic clk;
   logic reset;

   int n_cmp = 0;
   int n_bad = 0;

   uart_send_if u_if ();

   uart_send #(
      .CLK_FREQ     (12_000_000),
      .BAUD         (115200),
      .CLKS_PER_BIT (N)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; outputs are looked at 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected line level for bit slot idx (0 start, 1..8 data LSB first, 9 stop).
   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx == 9) return 1'b1;
      return b[idx-1];
   endfunction

   // Called at the sample right after the acceptance edge. Checks all 10N
   // busy cycles and the idle sample at edge k+10N, where it returns.
   task automatic check_frame(input string tag, input logic [7:0] b,
                              input bit chg, input logic [7:0] new_data);
      for (int c = 0; c < 10*N; c++) begin
         if (chg && c == 5*N) u_if.tx_data = new_data;
         chk($sformatf("%s tx c%0d", tag, c), 32'(u_if.tx), 32'(frame_bit(b, c / N)));
         chk($sformatf("%s busy c%0d", tag, c), 32'(u_if.tx_busy), 32'd1);
         step();
      end
      chk({tag, " busy end"}, 32'(u_if.tx_busy), 32'd0);
      chk({tag, " tx end"}, 32'(u_if.tx), 32'd1);
   endtask

   initial begin
      reset              = 1'b1;
      u_if.tx_data_ready = 1'b1;
      u_if.tx_data       = 8'hFF;
      u_if.address       = 8'h00;
      u_if.data_in       = 8'h00;
      u_if.write_enable  = 1'b0;

      // 1. reset with a pending request
      for (int i = 0; i < 2; i++) begin
         step();
         chk("rst tx", 32'(u_if.tx), 32'd1);
         chk("rst busy", 32'(u_if.tx_busy), 32'd0);
         chk("rst data_out", 32'(u_if.data_out), 32'd0);
      end
      u_if.tx_data_ready = 1'b0;
      reset = 1'b0;
      step();
      chk("post rst tx", 32'(u_if.tx), 32'd1);
      chk("post rst busy", 32'(u_if.tx_busy), 32'd0);

      // 2. single byte 0x43
      u_if.tx_data = 8'h43;
      u_if.tx_data_ready = 1'b1;
      step();
      u_if.tx_data_ready = 1'b0;
      check_frame("f43", 8'h43, 1'b0, 8'h00);
      step();
      chk("f43 stays idle", 32'(u_if.tx_busy), 32'd0);

      // 3. back-to-back: 0x55 with tx_data changed to 0xAA mid-frame
      u_if.tx_data = 8'h55;
      u_if.tx_data_ready = 1'b1;
      step();
      check_frame("f55", 8'h55, 1'b1, 8'hAA);
      step();
      u_if.tx_data_ready = 1'b0;
      check_frame("fAA", 8'hAA, 1'b0, 8'h00);
      step();
      chk("b2b stops", 32'(u_if.tx_busy), 32'd0);
      chk("b2b stops tx", 32'(u_if.tx), 32'd1);

      // 4. reset during data bit 3 of 0x00, then a clean 0x01
      u_if.tx_data = 8'h00;
      u_if.tx_data_ready = 1'b1;
      step();
      u_if.tx_data_ready = 1'b0;
      for (int i = 0; i < 4*N + 1; i++) step();
      chk("abort bit3 low", 32'(u_if.tx), 32'd0);
      reset = 1'b1;
      step();
      chk("abort tx", 32'(u_if.tx), 32'd1);
      chk("abort busy", 32'(u_if.tx_busy), 32'd0);
      reset = 1'b0;
      step();
      chk("abort idle", 32'(u_if.tx_busy), 32'd0);
      u_if.tx_data = 8'h01;
      u_if.tx_data_ready = 1'b1;
      step();
      u_if.tx_data_ready = 1'b0;
      check_frame("f01", 8'h01, 1'b0, 8'h00);

      // 5. RAM
      u_if.address = 8'h00; u_if.data_in = 8'hA5; u_if.write_enable = 1'b1;
      step();
      u_if.address = 8'hFF; u_if.data_in = 8'h3C;
      step();
      u_if.write_enable = 1'b0;
      u_if.address = 8'h00;
      step();
      chk("ram rd 00", 32'(u_if.data_out), 32'hA5);
      u_if.address = 8'hFF;
      step();
      chk("ram rd ff", 32'(u_if.data_out), 32'h3C);
      u_if.address = 8'h00; u_if.data_in = 8'h11; u_if.write_enable = 1'b1;
      step();
      chk("ram read-first", 32'(u_if.data_out), 32'hA5);
      u_if.write_enable = 1'b0;
      step();
      chk("ram new value", 32'(u_if.data_out), 32'h11);
      reset = 1'b1;
      u_if.address = 8'hFF; u_if.data_in = 8'h77; u_if.write_enable = 1'b1;
      step();
      chk("ram rst data_out", 32'(u_if.data_out), 32'h00);
      reset = 1'b0;
      u_if.write_enable = 1'b0;
      step();
      chk("ram keep ff", 32'(u_if.data_out), 32'h3C);
      u_if.address = 8'h00;
      step();
      chk("ram keep 00", 32'(u_if.data_out), 32'h11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
